// File: rtl/det_seq_ctrl_pkg.sv
// Shared definitions for the pattern-detector sequencing controller.
// Holds the default datapath sizes and the controller state encoding.
package det_seq_ctrl_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_CNT_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/det_seq_ctrl_rr_arb2.sv
// Two-way round-robin arbiter with a registered last-served pointer.
// Ports:
//   clk, reset    : clock, synchronous active-low reset
//   req0, req1    : requests (already qualified by the caller)
//   adv           : pointer may advance when a grant is issued
//   gnt0, gnt1    : combinational one-hot grant
module rr_arb2 (
    input  logic clk,
    input  logic reset,
    input  logic req0,
    input  logic req1,
    input  logic adv,
    output logic gnt0,
    output logic gnt1
);

    // 1 = requester 1 served last, so requester 0 wins the next tie
    logic last;

    // Lone request always wins; on a tie the one not served last wins
    always_comb begin
        gnt0 = req0 & (~req1 | last);
        gnt1 = req1 & (~req0 | ~last);
    end

    // Pointer follows every issued grant
    always_ff @(posedge clk) begin
        if (!reset) begin
            last <= 1'b1;
        end else if (adv && (gnt0 || gnt1)) begin
            last <= gnt1;
        end
    end

endmodule

// File: rtl/det_seq_ctrl.sv
// Sequencing controller: arbitrates two word requesters, clears the serial
// detector, shifts the granted word in MSB-first and counts detector hits.
// Ports:
//   clk, reset          : clock, synchronous active-low reset
//   req0/req1, data0/1  : requester handshakes and words
//   gnt0/gnt1           : one-cycle grants (combinational in IDLE)
//   det_a, det_clr      : serial bit and clear pulse to the detector
//   det_b               : detector Moore output
//   busy, done          : activity flag and end-of-transaction pulse
//   match_cnt, owner    : saturating hit count and last served requester
module det_seq_ctrl
    import det_seq_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             det_a,
    output logic             det_clr,
    input  logic             det_b,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] match_cnt,
    output logic             owner
);

    localparam int unsigned BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   sreg;
    logic [BIT_W-1:0]   bit_cnt;
    logic               arb_en;
    logic               granted;
    logic               counting;

    // Grants only in IDLE and never while reset is held
    assign arb_en   = (state == ST_IDLE) && reset;
    assign granted  = gnt0 | gnt1;
    assign counting = (state == ST_SHIFT) || (state == ST_DRAIN);

    rr_arb2 u_arb (
        .clk   (clk),
        .reset (reset),
        .req0  (req0 & arb_en),
        .req1  (req1 & arb_en),
        .adv   (arb_en),
        .gnt0  (gnt0),
        .gnt1  (gnt1)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (granted) state_next = ST_CLEAR;
            ST_CLEAR: state_next = ST_SHIFT;
            ST_SHIFT: if (bit_cnt == '0) state_next = ST_DRAIN;
            ST_DRAIN: state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Moore outputs decoded from state and the shift register
    always_comb begin
        busy    = 1'b0;
        det_a   = 1'b0;
        det_clr = 1'b0;
        done    = 1'b0;
        case (state)
            ST_IDLE:  ;
            ST_CLEAR: begin busy = 1'b1; det_clr = 1'b1; end
            ST_SHIFT: begin busy = 1'b1; det_a = sreg[WIDTH-1]; end
            ST_DRAIN: busy = 1'b1;
            ST_DONE:  begin busy = 1'b1; done = 1'b1; end
            default:  ;
        endcase
    end

    // Shift register, bit counter, owner and saturating match counter
    always_ff @(posedge clk) begin
        if (!reset) begin
            sreg      <= '0;
            bit_cnt   <= '0;
            match_cnt <= '0;
            owner     <= 1'b0;
        end else begin
            if (state == ST_IDLE && granted) begin
                sreg      <= gnt1 ? data1 : data0;
                owner     <= gnt1;
                match_cnt <= '0;
                bit_cnt   <= BIT_W'(WIDTH - 1);
            end
            if (state == ST_SHIFT) begin
                sreg    <= sreg << 1;
                bit_cnt <= bit_cnt - BIT_W'(1);
            end
            // det_b is the detector's response to the previous det_a
            if (counting && det_b && (match_cnt != {CNT_W{1'b1}})) begin
                match_cnt <= match_cnt + CNT_W'(1);
            end
        end
    end

endmodule
